elevator_car_ctrl: RTL and testbench
====================================

Name: elevator_car_ctrl

Overview:
Downstream consumer of elevator_queue. Reads the pending-floor bitmap (queue_data) and selects the next target floor using a SCAN (keep-direction) policy. Sequences car motion floor by floor, opens the door on arrival, and clears the serviced request bit back into the queue through r_nwr/clear_bit. Drives the motor and door indicators for the car.

Parameters:
FLOOR_COUNT, 7, number of floors; matches the queue bitmap width.
FLOOR_W, 3, width of floor index (>= clog2(FLOOR_COUNT)).
TRAVEL_CYCLES, 8, clock cycles to move one floor (>= 2).
DOOR_CYCLES, 16, clock cycles the door stays open (>= 2).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
queue_data  input  FLOOR_COUNT  pending request bitmap from elevator_queue; bit i = floor i requested.
r_nwr  output  1  queue access mode; 1 = read, 0 = write (clear).
clear_bit  output  1  one-cycle strobe; clears queue bit clear_floor.
clear_floor  output  FLOOR_W  index of bit to clear; valid when clear_bit = 1.
current_floor  output  FLOOR_W  floor the car is at or last passed.
motor_up  output  1  car moving up.
motor_down  output  1  car moving down.
door_open  output  1  door open.
busy  output  1  state != IDLE.

Behaviour:
- Reset (reset = 0, async): state IDLE, current_floor 0, dir = up, timers 0, r_nwr 1, clear_bit 0, clear_floor 0, motor_up/motor_down/door_open/busy 0.
- All outputs are registered and Moore-decoded from state. motor_up and motor_down are never both 1.
- r_nwr = 0 only in the cycle where clear_bit = 1; it is 1 otherwise.
- States: IDLE, MOVING, ARRIVE, DOOR_OPEN.
- Definitions: above = OR of queue_data bits above current_floor; below = OR of bits below current_floor; here = queue_data[current_floor].
- IDLE transitions:
  - If here -> ARRIVE.
  - Else if above and (dir = up or !below) -> dir = up, MOVING.
  - Else if below -> dir = down, MOVING.
  - Else stay IDLE.
  - here takes priority over above/below.
- MOVING:
  - motor_up = dir up, motor_down = dir down.
  - Travel timer counts 0..TRAVEL_CYCLES-1. On terminal count, current_floor steps ±1 and the timer is reset.
  - The decision uses the new floor value on the following cycle:
    - queue_data[floor] set -> ARRIVE.
    - Else requests remain ahead in dir -> continue MOVING.
    - Else -> IDLE. IDLE handles any reversal, so the motor is off for at least one cycle before a reversal.
- Floor bounds: current_floor never goes below 0 or above FLOOR_COUNT-1. If no request exists ahead at an end floor, MOVING exits to IDLE.
- ARRIVE (exactly one cycle):
  - clear_bit 1, r_nwr 0, clear_floor = current_floor, motors 0, door_open 0.
  - Next state DOOR_OPEN; door timer cleared.
- DOOR_OPEN:
  - door_open 1 for DOOR_CYCLES cycles, then -> IDLE.
  - If queue_data[current_floor] reasserts during DOOR_OPEN -> ARRIVE (re-clear), then door timer restarts.
- Requests that appear or vanish mid-travel are re-evaluated at each floor boundary only.
- queue_data = 0 while MOVING: complete the current floor step, then IDLE.
- Reset mid-operation: immediate return to the reset values above; the queue contents are untouched.
- Latency:
  - A request at current floor seen in IDLE -> clear_bit high in the next cycle.
  - Adjacent-floor request -> motion starts the next cycle; ARRIVE occurs TRAVEL_CYCLES+1 cycles after motion starts.

Test Plan:
- Reset held low, queue_data=7'b0000000 -> all outputs 0 except r_nwr=1; release, no activity, busy stays 0.
- Car at 0, queue_data=7'b0000001 -> next cycle clear_bit=1, r_nwr=0, clear_floor=0; then door_open=1 for 16 cycles; then IDLE.
- Car at 0, queue_data=7'b0001000 -> motor_up for 3 floor steps (8 cycles each); clear_floor=3 pulse; door opens; current_floor=3.
- Car at 3, dir up, queue_data=7'b1000010 -> goes up to 6 first and clears it (bench drops bit 6); after the door cycle, motor idle one cycle, then moves down to 1 and clears 1.
- Car moving 0->5 with queue_data=7'b0100000; bit 2 set mid-step 1->2 -> stops at 2 (clear_floor=2), door cycle, then resumes to 5.
- reset pulsed low mid-MOVING at floor 4 -> outputs return to reset values immediately (current_floor=0, motors 0); after release, replays per queue_data.

Source files
------------

// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elevator_car_ctrl
// Purpose  : SCAN-policy car sequencer consuming the elevator_queue bitmap.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_car_ctrl #(
  parameter int FLOOR_COUNT   = 7,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FLOOR_COUNT-1:0] queue_data,
  output logic                   r_nwr,
  output logic                   clear_bit,
  output logic [FLOOR_W-1:0]     clear_floor,
  output logic [FLOOR_W-1:0]     current_floor,
  output logic                   motor_up,
  output logic                   motor_down,
  output logic                   door_open,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVING    = 2'd1,
    S_ARRIVE    = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_t;

  localparam int C_TRAVEL_W = $clog2(TRAVEL_CYCLES);
  localparam int C_DOOR_W   = $clog2(DOOR_CYCLES);
  localparam logic [C_TRAVEL_W-1:0] C_TRAVEL_LAST = C_TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [C_DOOR_W-1:0]   C_DOOR_LAST   = C_DOOR_W'(DOOR_CYCLES - 1);

  state_t                r_state;
  logic                  r_dir_up;
  logic                  r_check;
  logic [C_TRAVEL_W-1:0] r_travel_cnt;
  logic [C_DOOR_W-1:0]   r_door_cnt;

  logic w_above;
  logic w_below;
  logic w_here;
  logic w_ahead;

  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    w_here  = 1'b0;
    for (int i = 0; i < FLOOR_COUNT; i++) begin
      if (i > int'(current_floor))  w_above = w_above | queue_data[i];
      if (i < int'(current_floor))  w_below = w_below | queue_data[i];
      if (i == int'(current_floor)) w_here  = queue_data[i];
    end
  end

  assign w_ahead = r_dir_up ? w_above : w_below;

  // Outputs are written alongside each state transition so they reflect the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_dir_up      <= 1'b1;
      r_check       <= 1'b0;
      r_travel_cnt  <= '0;
      r_door_cnt    <= '0;
      current_floor <= '0;
      r_nwr         <= 1'b1;
      clear_bit     <= 1'b0;
      clear_floor   <= '0;
      motor_up      <= 1'b0;
      motor_down    <= 1'b0;
      door_open     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_nwr     <= 1'b1;
      clear_bit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_here) begin
            r_state     <= S_ARRIVE;
            clear_bit   <= 1'b1;
            r_nwr       <= 1'b0;
            clear_floor <= current_floor;
            busy        <= 1'b1;
          end else if (w_above && (r_dir_up || !w_below)) begin
            r_state      <= S_MOVING;
            r_dir_up     <= 1'b1;
            r_travel_cnt <= '0;
            r_check      <= 1'b0;
            motor_up     <= 1'b1;
            motor_down   <= 1'b0;
            busy         <= 1'b1;
          end else if (w_below) begin
            r_state      <= S_MOVING;
            r_dir_up     <= 1'b0;
            r_travel_cnt <= '0;
            r_check      <= 1'b0;
            motor_up     <= 1'b0;
            motor_down   <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_MOVING: begin
          // r_check marks the first cycle at a new floor; it also counts as travel cycle 0.
          if (r_check) begin
            r_check <= 1'b0;
            if (w_here) begin
              r_state     <= S_ARRIVE;
              clear_bit   <= 1'b1;
              r_nwr       <= 1'b0;
              clear_floor <= current_floor;
              motor_up    <= 1'b0;
              motor_down  <= 1'b0;
            end else if (w_ahead) begin
              r_travel_cnt <= C_TRAVEL_W'(1);
            end else begin
              r_state    <= S_IDLE;
              motor_up   <= 1'b0;
              motor_down <= 1'b0;
              busy       <= 1'b0;
            end
          end else if (r_travel_cnt == C_TRAVEL_LAST) begin
            current_floor <= r_dir_up ? current_floor + FLOOR_W'(1)
                                      : current_floor - FLOOR_W'(1);
            r_travel_cnt  <= '0;
            r_check       <= 1'b1;
          end else begin
            r_travel_cnt <= r_travel_cnt + C_TRAVEL_W'(1);
          end
        end
        S_ARRIVE: begin
          r_state    <= S_DOOR_OPEN;
          r_door_cnt <= '0;
          door_open  <= 1'b1;
        end
        S_DOOR_OPEN: begin
          if (w_here) begin
            r_state     <= S_ARRIVE;
            clear_bit   <= 1'b1;
            r_nwr       <= 1'b0;
            clear_floor <= current_floor;
            door_open   <= 1'b0;
          end else if (r_door_cnt == C_DOOR_LAST) begin
            r_state   <= S_IDLE;
            door_open <= 1'b0;
            busy      <= 1'b0;
          end else begin
            r_door_cnt <= r_door_cnt + C_DOOR_W'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          motor_up   <= 1'b0;
          motor_down <= 1'b0;
          door_open  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_car_ctrl
// Purpose  : Scoreboard bench for elevator_car_ctrl with a modelled request queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_car_ctrl;

  localparam int C_T = 8;
  localparam int C_D = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] queue_data = 7'b0;
  logic       r_nwr;
  logic       clear_bit;
  logic [2:0] clear_floor;
  logic [2:0] current_floor;
  logic       motor_up;
  logic       motor_down;
  logic       door_open;
  logic       busy;

  typedef struct {
    int floor;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  elevator_car_ctrl #(
    .FLOOR_COUNT  (7),
    .FLOOR_W      (3),
    .TRAVEL_CYCLES(C_T),
    .DOOR_CYCLES  (C_D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .queue_data   (queue_data),
    .r_nwr        (r_nwr),
    .clear_bit    (clear_bit),
    .clear_floor  (clear_floor),
    .current_floor(current_floor),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, score clear strobes, retire cleared bits.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    check_value("motor_excl", int'(motor_up & motor_down), 0);
    check_value("nwr_vs_clr", int'(r_nwr), int'(!clear_bit));
    if (clear_bit) begin
      if (sb.size() == 0) begin
        check_value("clr_spurious", int'(clear_floor), -1);
      end else begin
        e = sb.pop_front();
        check_value("clr_floor", int'(clear_floor), e.floor);
        check_value("clr_cycle", cyc, e.cyc);
        check_value("clr_at_floor", int'(current_floor), e.floor);
        check_value("clr_door", int'(door_open | motor_up | motor_down), 0);
      end
      queue_data[clear_floor] = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check_value("sb_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      cycle();
      n++;
    end
    check_value("idle_timeout", int'(busy), 0);
  endtask

  task automatic push(input int floor, input int at);
    exp_t e;
    e.floor = floor;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  initial begin
    int c0;
    int n;

    // Reset held low
    repeat (2) cycle();
    check_value("rst_nwr", int'(r_nwr), 1);
    check_value("rst_outs", int'({clear_bit, motor_up, motor_down, door_open, busy}), 0);
    check_value("rst_floor", int'(current_floor), 0);
    reset = 1'b1;
    repeat (4) cycle();
    check_value("quiet_busy", int'(busy), 0);

    // Request at the current floor, then a full door cycle
    c0 = cyc;
    queue_data = 7'b0000001;
    push(0, c0 + 1);
    wait_drain(10);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (door_open) n++;
      else if (n > 0) break;
    end
    check_value("door_len", n, C_D);
    check_value("idle_after_door", int'(busy), 0);

    // Travel 0 -> 3
    c0 = cyc;
    queue_data = 7'b0001000;
    push(3, c0 + 2 + 3 * C_T);
    repeat (12) cycle();
    check_value("mv_up_motor", int'(motor_up), 1);
    check_value("mv_up_floor", int'(current_floor), 1);
    wait_drain(60);
    wait_idle(40);

    // SCAN: 6 first while heading up, then reverse to 1
    c0 = cyc;
    queue_data = 7'b1000010;
    push(6, c0 + 2 + 3 * C_T);
    push(1, c0 + 2 + 3 * C_T + 18 + 1 + 5 * C_T);
    while (sb.size() == 2 && cyc < c0 + 60) cycle();
    check_value("scan_first", int'(current_floor), 6);
    repeat (17) cycle();
    check_value("rev_gap_busy", int'(busy), 0);
    check_value("rev_gap_motor", int'(motor_up | motor_down), 0);
    cycle();
    check_value("rev_down", int'(motor_down), 1);
    wait_drain(80);
    wait_idle(40);

    // Back to floor 0 via reset, then a request inserted mid-step 1->2
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    c0 = cyc;
    queue_data = 7'b0100000;
    push(2, c0 + 2 + 2 * C_T);
    push(5, c0 + 2 + 2 * C_T + 18 + 1 + 3 * C_T);
    repeat (12) cycle();
    queue_data[2] = 1'b1;
    wait_drain(100);
    wait_idle(40);
    check_value("resume_floor", int'(current_floor), 5);

    // Queue emptied mid-step: finish the step to 4, then idle
    c0 = cyc;
    queue_data = 7'b0001000;
    repeat (5) cycle();
    queue_data = 7'b0000000;
    repeat (7) cycle();
    check_value("empty_busy", int'(busy), 0);
    check_value("empty_floor", int'(current_floor), 4);

    // Reset mid-motion at floor 4; queue kept, request replays from floor 0
    queue_data = 7'b0000001;
    repeat (4) cycle();
    check_value("pre_rst_floor", int'(current_floor), 4);
    check_value("pre_rst_motor", int'(motor_down), 1);
    reset = 1'b0;
    #1;
    check_value("mid_rst_floor", int'(current_floor), 0);
    check_value("mid_rst_outs", int'({clear_bit, motor_up, motor_down, door_open, busy}), 0);
    check_value("mid_rst_nwr", int'(r_nwr), 1);
    cycle();
    reset = 1'b1;
    push(0, cyc + 1);
    wait_drain(10);
    wait_idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
